// File: rtl/dvsd_mul_arb.sv
`default_nettype none
// ============================================================================
// dvsd_mul_arb : two requesters sharing one 8x8 Dadda multiplier core.
// Define DVSD_MUL_ARB_RR_EN for round-robin grant; otherwise requester 0 wins.
// Revision: 1.0
// ============================================================================

module dvsd_mul_arb_dadda8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] prod
);

  // Column-wise Dadda reduction (heights 6,4,3,2), then one carry-propagate add.
  function automatic logic [15:0] dadda_reduce(input logic [7:0] x, input logic [7:0] y);
    logic [15:0][15:0] cur;
    logic [15:0][15:0] nxt;
    int                cur_n [16];
    int                nxt_n [16];
    int                d;
    int                rem;
    int                idx;
    logic              p;
    logic              q;
    logic              r;
    logic              carry;
    logic [15:0]       row0;
    logic [15:0]       row1;

    cur = '0;
    for (int c = 0; c < 16; c++) cur_n[c] = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        cur[i+j][cur_n[i+j]] = x[i] & y[j];
        cur_n[i+j] = cur_n[i+j] + 1;
      end
    end

    for (int st = 0; st < 4; st++) begin
      case (st)
        0:       d = 6;
        1:       d = 4;
        2:       d = 3;
        default: d = 2;
      endcase
      nxt = '0;
      for (int c = 0; c < 16; c++) nxt_n[c] = 0;
      for (int c = 0; c < 16; c++) begin
        rem = cur_n[c];
        idx = 0;
        for (int k = 0; k < 8; k++) begin
          if ((nxt_n[c] + rem > d) && (rem >= 2)) begin
            p = cur[c][idx];
            q = cur[c][idx+1];
            if ((nxt_n[c] + rem - d >= 2) && (rem >= 3)) begin
              r     = cur[c][idx+2];
              nxt[c][nxt_n[c]] = p ^ q ^ r;
              carry = (p & q) | (p & r) | (q & r);
              idx   = idx + 3;
              rem   = rem - 3;
            end else begin
              nxt[c][nxt_n[c]] = p ^ q;
              carry = p & q;
              idx   = idx + 2;
              rem   = rem - 2;
            end
            nxt_n[c] = nxt_n[c] + 1;
            if (c < 15) begin
              nxt[c+1][nxt_n[c+1]] = carry;
              nxt_n[c+1] = nxt_n[c+1] + 1;
            end
          end
        end
        for (int k = 0; k < 16; k++) begin
          if (k < rem) begin
            nxt[c][nxt_n[c]] = cur[c][idx+k];
            nxt_n[c] = nxt_n[c] + 1;
          end
        end
      end
      cur   = nxt;
      cur_n = nxt_n;
    end

    for (int c = 0; c < 16; c++) begin
      row0[c] = cur[c][0];
      row1[c] = cur[c][1];
    end
    return row0 + row1;
  endfunction

  assign prod = dadda_reduce(a, b);

endmodule

module dvsd_mul_arb #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_prod,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       op_a_q, op_a_d;
  logic [7:0]       op_b_q, op_b_d;
  logic             op_id_q, op_id_d;
  logic [15:0]      prod_q, prod_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      core_prod;
  logic             gnt_id;
  logic             accept;

  assign accept = (state_q == ST_IDLE) && (req0_valid || req1_valid);

`ifdef DVSD_MUL_ARB_RR_EN
  // rr_ptr_q names the requester preferred on the next contended grant.
  logic rr_ptr_q, rr_ptr_d;

  assign gnt_id = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = ~gnt_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= 1'b0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  assign gnt_id = req1_valid && !req0_valid;
`endif

  dvsd_mul_arb_dadda8 u_core (
    .a    (op_a_q),
    .b    (op_b_q),
    .prod (core_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    op_id_d = op_id_q;
    prod_d  = prod_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_a_d  = gnt_id ? req1_a : req0_a;
          op_b_d  = gnt_id ? req1_b : req0_b;
          op_id_d = gnt_id;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        prod_d  = core_prod;
        id_d    = op_id_q;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = (state_q == ST_RESP);
    busy       = (state_q != ST_IDLE);
    if (state_q == ST_IDLE) begin
      req0_ready = req0_valid && !gnt_id;
      req1_ready = req1_valid && gnt_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      op_id_q <= 1'b0;
      prod_q  <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      op_id_q <= op_id_d;
      prod_q  <= prod_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_prod = prod_q;
  assign rsp_id   = id_q;
  assign done_cnt = cnt_q;

endmodule
`default_nettype wire
